// File: rtl/sprite_if.sv
// Signal bundle between the VGA timing generator / game logic and the sprite renderer.
interface sprite_if;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        bright;
    logic        frameStart;
    logic [9:0]  spriteX;
    logic [9:0]  spriteY;
    logic        spriteFlip;
    logic        romWe;
    logic [7:0]  romWAddr;
    logic [11:0] romWData;
    logic [11:0] rgb;
    logic        spriteShown;

    modport master (
        output hCount, vCount, bright, frameStart,
        output spriteX, spriteY, spriteFlip,
        output romWe, romWAddr, romWData,
        input  rgb, spriteShown
    );

    modport slave (
        input  hCount, vCount, bright, frameStart,
        input  spriteX, spriteY, spriteFlip,
        input  romWe, romWAddr, romWData,
        output rgb, spriteShown
    );
endinterface

// File: rtl/sprite_renderer.sv
// Pixel-colour stage behind the VGA timing generator: draws one 16x16 sprite
// from a loadable 256x12 pattern RAM over a flat background, with the sprite
// position double-buffered at frame start and a per-frame "sprite drawn" flag.
module sprite_renderer #(
    parameter logic [9:0]  H_ORIGIN    = 10'd144,
    parameter logic [9:0]  V_ORIGIN    = 10'd35,
    parameter logic [11:0] BG_COLOR    = 12'h124,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic    clk,
    input  logic    rst,
    sprite_if.slave bus
);
    logic        fs_prev;
    logic        latch;
    logic [9:0]  act_x;
    logic [9:0]  act_y;
    logic        act_flip;

    logic [9:0]  sx;
    logic [9:0]  sy;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic        in_sprite;
    logic [3:0]  col;

    logic        in_p1;
    logic        vld_p1;
    logic [7:0]  addr_p1;
    logic        in_p2;
    logic        vld_p2;
    logic [11:0] pix_p2;

    logic [11:0] mem [0:255];

    logic        opaque;
    logic        hit;
    logic        hit_acc;
    logic        shown;

    // One-clock latch pulse on the rising edge of frameStart.
    assign latch = bus.frameStart && !fs_prev;

    // Shadow position/flip registers, only updated at the frame boundary so a move never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs_prev  <= 1'b0;
            act_x    <= '0;
            act_y    <= '0;
            act_flip <= 1'b0;
        end else begin
            fs_prev <= bus.frameStart;
            if (latch) begin
                act_x    <= bus.spriteX;
                act_y    <= bus.spriteY;
                act_flip <= bus.spriteFlip;
            end
        end
    end

    // Screen-relative and sprite-relative offsets; 10-bit wrap makes left/top of sprite fail dx<16.
    always_comb begin
        sx        = bus.hCount - H_ORIGIN;
        sy        = bus.vCount - V_ORIGIN;
        dx        = sx - act_x;
        dy        = sy - act_y;
        in_sprite = bus.bright && (dx < 10'd16) && (dy < 10'd16);
        col       = act_flip ? (4'd15 - dx[3:0]) : dx[3:0];
    end

    // Stage 1: sprite window test and pattern address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_p1   <= 1'b0;
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
        end else begin
            in_p1   <= in_sprite;
            vld_p1  <= bus.bright;
            addr_p1 <= {dy[3:0], col};
        end
    end

    // Pattern RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.romWe) begin
            mem[bus.romWAddr] <= bus.romWData;
        end
    end

    // Stage 2: synchronous pattern read (a same-clock write is not yet visible, so old data returns).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_p2  <= 1'b0;
            vld_p2 <= 1'b0;
            pix_p2 <= '0;
        end else begin
            in_p2  <= in_p1;
            vld_p2 <= vld_p1;
            pix_p2 <= mem[addr_p1];
        end
    end

    assign opaque = in_p2 && (pix_p2 != TRANSPARENT);
    assign hit    = vld_p2 && opaque;

    // Per-frame hit accumulator; a hit coinciding with the latch belongs to the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_acc <= 1'b0;
            shown   <= 1'b0;
        end else if (latch) begin
            shown   <= hit_acc;
            hit_acc <= hit;
        end else if (hit) begin
            hit_acc <= 1'b1;
        end
    end

    assign bus.rgb         = !vld_p2 ? 12'h000 : (opaque ? pix_p2 : BG_COLOR);
    assign bus.spriteShown = shown;
endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer with a reference-model scoreboard on rgb.
module tb_sprite_renderer;
    localparam logic [9:0]  H_ORG  = 10'd144;
    localparam logic [9:0]  V_ORG  = 10'd35;
    localparam logic [11:0] BG     = 12'h124;
    localparam logic [11:0] TRANSP = 12'hF0F;

    logic clk = 1'b0;
    logic rst;

    sprite_if bus();

    sprite_renderer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] rgb;
        logic [9:0]  h;
        logic [9:0]  v;
    } req_t;

    req_t        sb[$];
    logic [11:0] m_mem [0:255];
    logic [9:0]  m_ax;
    logic [9:0]  m_ay;
    logic        m_flip;
    logic        m_fs_prev;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s: observed %h required %h", tag, obs, req);
        end
    endtask

    // Model state after reset: position (0,0), empty pipeline (next rgb is 0).
    task automatic model_reset();
        req_t z;
        m_ax      = '0;
        m_ay      = '0;
        m_flip    = 1'b0;
        m_fs_prev = 1'b0;
        sb.delete();
        z.rgb = 12'h000;
        z.h   = '0;
        z.v   = '0;
        sb.push_back(z);
    endtask

    // Drive one counter sample, predict its pixel, and check the pixel two clocks old.
    task automatic tick(input logic [9:0] h, input logic [9:0] v, input logic b, input logic fs);
        logic [9:0]  sx, sy, dx, dy;
        logic [3:0]  col;
        logic [11:0] pix;
        req_t        e;
        req_t        got;
        bus.hCount     = h;
        bus.vCount     = v;
        bus.bright     = b;
        bus.frameStart = fs;
        if (bus.romWe) m_mem[bus.romWAddr] = bus.romWData;
        sx  = h - H_ORG;
        sy  = v - V_ORG;
        dx  = sx - m_ax;
        dy  = sy - m_ay;
        col = m_flip ? (4'd15 - dx[3:0]) : dx[3:0];
        pix = m_mem[{dy[3:0], col}];
        e.h = h;
        e.v = v;
        if (!b) e.rgb = 12'h000;
        else if (dx < 10'd16 && dy < 10'd16 && pix !== TRANSP) e.rgb = pix;
        else e.rgb = BG;
        if (fs && !m_fs_prev) begin
            m_ax   = bus.spriteX;
            m_ay   = bus.spriteY;
            m_flip = bus.spriteFlip;
        end
        m_fs_prev = fs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() >= 2) begin
            got = sb.pop_front();
            chk($sformatf("rgb h=%0d v=%0d", got.h, got.v), bus.rgb, got.rgb);
        end
    endtask

    task automatic blank();
        tick(10'd799, 10'd524, 1'b0, 1'b0);
    endtask

    task automatic frame_start();
        repeat (3) blank();
        repeat (4) tick(10'd0, 10'd0, 1'b0, 1'b1);
    endtask

    task automatic scan(input int h0, input int h1, input int v0, input int v1);
        for (int v = v0; v <= v1; v++) begin
            for (int h = h0; h <= h1; h++) begin
                tick(10'(h), 10'(v), (h >= 144 && h < 784 && v >= 35 && v < 515), 1'b0);
            end
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [11:0] d);
        bus.romWe    = 1'b1;
        bus.romWAddr = a;
        bus.romWData = d;
        tick(10'd799, 10'd10, 1'b0, 1'b0);
        bus.romWe    = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.hCount     = '0;
        bus.vCount     = '0;
        bus.bright     = 1'b0;
        bus.frameStart = 1'b0;
        bus.spriteX    = '0;
        bus.spriteY    = '0;
        bus.spriteFlip = 1'b0;
        bus.romWe      = 1'b0;
        bus.romWAddr   = '0;
        bus.romWData   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rgb", bus.rgb, 12'h000);
        chk("reset spriteShown", {11'd0, bus.spriteShown}, 12'h000);
        model_reset();
        rst = 1'b0;

        // T1: visible pixels away from the (0,0) sprite show background, then reset mid-line
        repeat (4) tick(10'd300, 10'd200, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("async reset rgb", bus.rgb, 12'h000);
        chk("async reset spriteShown", {11'd0, bus.spriteShown}, 12'h000);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        repeat (3) tick(10'd301, 10'd200, 1'b1, 1'b0);
        blank();

        // T2: whole pattern green, sprite at (100,50)
        for (int a = 0; a < 256; a++) load(8'(a), 12'h0F0);
        bus.spriteX    = 10'd100;
        bus.spriteY    = 10'd50;
        bus.spriteFlip = 1'b0;
        frame_start();
        chk("shown after empty frame", {11'd0, bus.spriteShown}, 12'h000);
        scan(242, 261, 84, 101);

        // T3: row 0 holds column indices with a transparent column 3, mirrored
        for (int c = 0; c < 16; c++) load(8'(c), (c == 3) ? TRANSP : 12'(12'h100 + c));
        bus.spriteFlip = 1'b1;
        frame_start();
        chk("shown after T2 frame", {11'd0, bus.spriteShown}, 12'h001);
        scan(242, 261, 85, 86);

        // T4: move requested mid-frame only takes effect at the next frame
        bus.spriteFlip = 1'b0;
        frame_start();
        scan(242, 261, 88, 88);
        bus.spriteX = 10'd300;
        scan(242, 261, 90, 90);
        scan(442, 461, 90, 90);
        frame_start();
        scan(242, 261, 90, 90);
        scan(442, 461, 90, 90);

        // T5: off-screen sprite gives no hit, right-edge clipped sprite does
        bus.spriteX = 10'd700;
        frame_start();
        scan(768, 787, 88, 90);
        bus.spriteX = 10'd630;
        frame_start();
        chk("shown after off-screen frame", {11'd0, bus.spriteShown}, 12'h000);
        scan(768, 787, 88, 90);
        bus.spriteX = 10'd0;
        bus.spriteY = 10'd0;
        frame_start();
        chk("shown after clipped frame", {11'd0, bus.spriteShown}, 12'h001);

        // T6: write to the address being read returns old data, new data next frame
        tick(10'd144, 10'd35, 1'b1, 1'b0);
        bus.romWe    = 1'b1;
        bus.romWAddr = 8'h00;
        bus.romWData = 12'hABC;
        tick(10'd145, 10'd35, 1'b1, 1'b0);
        bus.romWe    = 1'b0;
        tick(10'd146, 10'd35, 1'b1, 1'b0);
        frame_start();
        tick(10'd144, 10'd35, 1'b1, 1'b0);
        tick(10'd145, 10'd35, 1'b1, 1'b0);
        blank();
        blank();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
